// File: rtl/ultrasonic_tof_ranger_pkg.sv
// Shared register map, CTRL/STATUS/DATA bit positions and FSM encoding for the TOF ranger.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ultrasonic_tof_ranger_pkg;

    // Register word indices on the Avalon-MM slave
    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_DATA    = 3'd2;
    localparam logic [2:0] ADDR_PERIOD  = 3'd3;
    localparam logic [2:0] ADDR_PULSE_W = 3'd4;
    localparam logic [2:0] ADDR_TIMEOUT = 3'd5;

    // CTRL bits
    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_TRIGGER  = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_FIFO_CLR = 3;

    // STATUS bits / fields
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_STATE_LSB = 16;

    // DATA bits
    localparam int DATA_VALID   = 31;
    localparam int DATA_TIMEOUT = 30;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_LISTEN = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

endpackage

// File: rtl/ultrasonic_tof_ranger_if.sv
// Avalon-MM register bus plus level interrupt for the TOF ranger.
// Latency: readdata is valid the cycle after avl_read.
// Backpressure: none; the slave never stalls (no waitrequest).
interface ultrasonic_tof_ranger_if;
    logic [2:0]  avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;
    logic        irq;

    modport master (
        output avl_address, avl_read, avl_write, avl_writedata,
        input  avl_readdata, irq
    );

    modport slave (
        input  avl_address, avl_read, avl_write, avl_writedata,
        output avl_readdata, irq
    );
endinterface

// File: rtl/ultrasonic_tof_ranger_tof_fifo.sv
// Synchronous show-ahead FIFO holding {timeout, tof} records.
// Latency: dout presents the head entry combinationally; push visible at head next cycle.
// Backpressure: push on full is dropped unless a pop happens in the same cycle; clr beats push/pop.
module ultrasonic_tof_ranger_tof_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign rd_ok = rd_en & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_ok = wr_en & (~full | rd_ok);
    assign dout  = mem[rd_ptr];

    // Record storage; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; clear takes priority over traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ultrasonic_tof_ranger.sv
// Ultrasonic ranging engine: fires bursts, times echo arrival, queues TOF records behind an Avalon-MM slave.
// Latency: register reads return one cycle after avl_read; echo edges are timestamped SYNC_STAGES cycles late.
// Backpressure: none on the bus; records arriving at a full FIFO are dropped and flagged as overflow.
module ultrasonic_tof_ranger
    import ultrasonic_tof_ranger_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEF_PERIOD  = 50000,
    parameter int DEF_PULSE_W = 500,
    parameter int DEF_TIMEOUT = 40000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ultrasonic_pulse,
    input  logic                    ultrasonic_echo,
    ultrasonic_tof_ranger_if.slave  avl
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REC_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_nxt;
    logic               ctrl_enable;
    logic               ctrl_irq_en;
    logic               overflow;
    logic [CNT_W-1:0]   period_reg;
    logic [CNT_W-1:0]   pulse_w_reg;
    logic [CNT_W-1:0]   timeout_reg;
    logic [CNT_W-1:0]   period_sh;
    logic [CNT_W-1:0]   pulse_w_sh;
    logic [CNT_W-1:0]   timeout_sh;
    logic [CNT_W-1:0]   pulse_w_eff;
    logic [CNT_W-1:0]   cnt;
    logic [SYNC_STAGES-1:0] echo_sync;
    logic               echo_prev;
    logic               echo_rise;
    logic               wr_ctrl;
    logic               wr_status;
    logic               trigger;
    logic               fifo_clr;
    logic               pop;
    logic               push;
    logic               push_timeout;
    logic [CNT_W-1:0]   push_tof;
    logic               burst_start;
    logic [REC_W-1:0]   fifo_din;
    logic [REC_W-1:0]   fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic [31:0]        rd_mux;
    logic               unused_wd;

    assign wr_ctrl   = avl.avl_write && (avl.avl_address == ADDR_CTRL);
    assign wr_status = avl.avl_write && (avl.avl_address == ADDR_STATUS);
    assign trigger   = wr_ctrl && avl.avl_writedata[CTRL_TRIGGER];
    assign fifo_clr  = wr_ctrl && avl.avl_writedata[CTRL_FIFO_CLR];
    assign pop       = avl.avl_read && (avl.avl_address == ADDR_DATA) && !fifo_empty;
    assign unused_wd = ^avl.avl_writedata[31:CNT_W];

    // A zero-length burst would never leave PULSE cleanly, so it runs for one cycle.
    assign pulse_w_eff = (pulse_w_sh == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : pulse_w_sh;

    assign ultrasonic_pulse = (state == ST_PULSE);
    assign avl.irq          = ctrl_irq_en & ~fifo_empty;
    assign fifo_din         = {push_timeout, push_tof};

    // Echo synchroniser followed by a one-flop rising-edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_sync <= '0;
            echo_prev <= 1'b0;
        end else begin
            echo_sync <= {echo_sync[SYNC_STAGES-2:0], ultrasonic_echo};
            echo_prev <= echo_sync[SYNC_STAGES-1];
        end
    end
    assign echo_rise = echo_sync[SYNC_STAGES-1] & ~echo_prev;

    // Burst FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Burst sequencing: next state, record push and burst-start strobe.
    always_comb begin
        state_nxt    = state;
        push         = 1'b0;
        push_timeout = 1'b0;
        push_tof     = cnt;
        burst_start  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ctrl_enable || trigger) begin
                    state_nxt   = ST_PULSE;
                    burst_start = 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt >= pulse_w_eff - 1'b1) state_nxt = ST_LISTEN;
            end
            ST_LISTEN: begin
                // An edge landing on the timeout cycle is a real echo, so it is checked first.
                if (echo_rise) begin
                    push      = 1'b1;
                    state_nxt = ST_GAP;
                end else if (cnt >= timeout_sh) begin
                    push         = 1'b1;
                    push_timeout = 1'b1;
                    push_tof     = timeout_sh;
                    state_nxt    = ST_GAP;
                end
            end
            ST_GAP: begin
                if ({1'b0, cnt} + 1'b1 >= {1'b0, period_sh}) begin
                    if (ctrl_enable) begin
                        state_nxt   = ST_PULSE;
                        burst_start = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // Shared TOF/period counter: zero on the first PULSE cycle, saturating thereafter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (burst_start) begin
            cnt <= '0;
        end else if (state != ST_IDLE && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow copies so config writes during a burst only apply from the next burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_sh  <= CNT_W'(DEF_PERIOD);
            pulse_w_sh <= CNT_W'(DEF_PULSE_W);
            timeout_sh <= CNT_W'(DEF_TIMEOUT);
        end else if (burst_start) begin
            period_sh  <= period_reg;
            pulse_w_sh <= pulse_w_reg;
            timeout_sh <= timeout_reg;
        end
    end

    // Register file writes and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_enable <= 1'b0;
            ctrl_irq_en <= 1'b0;
            overflow    <= 1'b0;
            period_reg  <= CNT_W'(DEF_PERIOD);
            pulse_w_reg <= CNT_W'(DEF_PULSE_W);
            timeout_reg <= CNT_W'(DEF_TIMEOUT);
        end else begin
            if (wr_ctrl) begin
                ctrl_enable <= avl.avl_writedata[CTRL_ENABLE];
                ctrl_irq_en <= avl.avl_writedata[CTRL_IRQ_EN];
            end
            if (avl.avl_write) begin
                case (avl.avl_address)
                    ADDR_PERIOD:  period_reg  <= avl.avl_writedata[CNT_W-1:0];
                    ADDR_PULSE_W: pulse_w_reg <= avl.avl_writedata[CNT_W-1:0];
                    ADDR_TIMEOUT: timeout_reg <= avl.avl_writedata[CNT_W-1:0];
                    default: ;
                endcase
            end
            // A fresh drop outranks a simultaneous clear so no loss goes unreported.
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (wr_status && avl.avl_writedata[STAT_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Read data selection.
    always_comb begin
        rd_mux = '0;
        case (avl.avl_address)
            ADDR_CTRL: begin
                rd_mux[CTRL_ENABLE] = ctrl_enable;
                rd_mux[CTRL_IRQ_EN] = ctrl_irq_en;
            end
            ADDR_STATUS: begin
                rd_mux[STAT_EMPTY]             = fifo_empty;
                rd_mux[STAT_FULL]              = fifo_full;
                rd_mux[STAT_OVF]               = overflow;
                rd_mux[STAT_LEVEL_LSB +: 8]    = 8'(fifo_level);
                rd_mux[STAT_STATE_LSB +: 3]    = {1'b0, state};
            end
            ADDR_DATA: begin
                if (!fifo_empty) begin
                    rd_mux[DATA_VALID]   = 1'b1;
                    rd_mux[DATA_TIMEOUT] = fifo_dout[CNT_W];
                    rd_mux[CNT_W-1:0]    = fifo_dout[CNT_W-1:0];
                end
            end
            ADDR_PERIOD:  rd_mux[CNT_W-1:0] = period_reg;
            ADDR_PULSE_W: rd_mux[CNT_W-1:0] = pulse_w_reg;
            ADDR_TIMEOUT: rd_mux[CNT_W-1:0] = timeout_reg;
            default: ;
        endcase
    end

    // Registered read data, updated only on a read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               avl.avl_readdata <= '0;
        else if (avl.avl_read) avl.avl_readdata <= rd_mux;
    end

    ultrasonic_tof_ranger_tof_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .wr_en (push),
        .din   (fifo_din),
        .rd_en (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );
endmodule

// File: tb/tb_ultrasonic_tof_ranger.sv
// Scoreboarded bench for the TOF ranger: randomized single shots checked against a ranging model,
// plus free-running overflow, period shadowing, irq and asynchronous reset scenarios.
// Reads push expectations into a queue; a monitor pops and compares when readdata becomes valid.
module tb_ultrasonic_tof_ranger;
    import ultrasonic_tof_ranger_pkg::*;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ultrasonic_pulse;
    logic ultrasonic_echo = 1'b0;

    ultrasonic_tof_ranger_if bus ();

    ultrasonic_tof_ranger dut (
        .clk              (clk),
        .rst              (rst),
        .ultrasonic_pulse (ultrasonic_pulse),
        .ultrasonic_echo  (ultrasonic_echo),
        .avl              (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic rd_seen;
    logic pulse_d = 1'b0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          rise_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Ranging model: an echo seen at tof e counts only after the burst and no later than the
    // point where the listen window closes; otherwise the record is a timeout carrying TIMEOUT.
    function automatic logic [31:0] exp_rec(input int pw, input int to, input int n);
        int pwe  = (pw == 0) ? 1 : pw;
        int tend = (to > pwe) ? to : pwe;
        int e    = n + SYNC;
        if (n >= 0 && e >= pwe && e <= tend) return 32'h8000_0000 | 32'(e);
        return 32'hC000_0000 | 32'(to);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) rd_seen <= 1'b0;
        else     rd_seen <= bus.avl_read;
    end

    // Monitor: readdata is valid the cycle after a read strobe.
    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_read: got %h expected no read", bus.avl_readdata);
            end else begin
                check(name_q.pop_front(), bus.avl_readdata, exp_q.pop_front());
            end
        end
    end

    // Burst start timestamps for spacing checks.
    always @(negedge clk) begin
        if (ultrasonic_pulse && !pulse_d) rise_q.push_back(cyc);
        pulse_d = ultrasonic_pulse;
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avl_address   = a;
        bus.avl_writedata = d;
        bus.avl_write     = 1'b1;
        @(negedge clk);
        bus.avl_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        bus.avl_address = a;
        bus.avl_read    = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        bus.avl_read    = 1'b0;
    endtask

    // One triggered burst; echo rises at the sample ending cycle n (n<0: never) and falls at off.
    task automatic shot(input int pw, input int to, input int n, input int off);
        int hi = 0;
        bus_write(ADDR_PULSE_W, pw);
        bus_write(ADDR_TIMEOUT, to);
        bus_write(ADDR_CTRL, 32'h2);
        for (int c = 0; c < 280; c++) begin
            if (c > 0) @(negedge clk);
            if (ultrasonic_pulse) hi++;
            if (c == n)   ultrasonic_echo = 1'b1;
            if (c == off) ultrasonic_echo = 1'b0;
        end
        ultrasonic_echo = 1'b0;
        check("pulse_width", hi, (pw == 0) ? 1 : pw);
        bus_read(ADDR_DATA, exp_rec(pw, to, n), "data_record");
        bus_read(ADDR_DATA, 32'h0, "data_after_pop");
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_rises(input int k);
        for (int i = 0; i < 3000 && rise_q.size() < k; i++) @(negedge clk);
        check("burst_starts_seen", (rise_q.size() >= k) ? 1 : 0, 1);
    endtask

    // Reset asserted asynchronously at cycle 'at' of a running burst with irq active.
    task automatic reset_mid(input int at);
        bus_write(ADDR_PERIOD, 300);
        bus_write(ADDR_PULSE_W, 5);
        bus_write(ADDR_TIMEOUT, 20);
        bus_write(ADDR_CTRL, 32'h2);
        repeat (320) @(negedge clk);
        bus_write(ADDR_PULSE_W, 30);
        bus_write(ADDR_TIMEOUT, 40000);
        bus_read(ADDR_PERIOD, 300, "period_readback");
        bus_write(ADDR_CTRL, 32'h6);
        repeat (at) @(negedge clk);
        check("pre_reset_irq", bus.irq, 1);
        check("pre_reset_pulse", ultrasonic_pulse, (at < 30) ? 1 : 0);
        #2 rst = 1'b1;
        #1;
        check("reset_pulse", ultrasonic_pulse, 0);
        check("reset_irq", bus.irq, 0);
        check("reset_readdata", bus.avl_readdata, 0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(ADDR_STATUS, 32'h1, "status_after_reset");
        bus_read(ADDR_PERIOD, 50000, "period_after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pw, to, n;
        int r0, r1, r2, r3;
        bus.avl_address   = '0;
        bus.avl_read      = 1'b0;
        bus.avl_write     = 1'b0;
        bus.avl_writedata = '0;
        repeat (3) @(negedge clk);
        check("reset_pulse_out", ultrasonic_pulse, 0);
        check("reset_irq_out", bus.irq, 0);
        check("reset_readdata_out", bus.avl_readdata, 0);
        rst = 1'b0;

        bus_read(ADDR_STATUS,  32'h1, "status_reset");
        bus_read(ADDR_CTRL,    32'h0, "ctrl_reset");
        bus_read(ADDR_PERIOD,  50000, "period_reset");
        bus_read(ADDR_PULSE_W, 500,   "pulse_w_reset");
        bus_read(ADDR_TIMEOUT, 40000, "timeout_reset");
        bus_read(ADDR_DATA,    32'h0, "data_reset_empty");
        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_read(3'd7, 32'h0, "addr7_reads_zero");
        bus_read(3'd6, 32'h0, "addr6_reads_zero");

        bus_write(ADDR_PERIOD, 300);
        // Directed shots: echo, timeout, blanking, edge on timeout, listen-window edges, zero burst.
        shot(10, 200, 50, 1000);
        shot(10, 200, -1, 1000);
        shot(40, 200, 3, 8);
        shot(10, 100, 98, 1000);
        shot(10, 200, 8, 1000);
        shot(10, 200, 7, 1000);
        shot(0, 30, -1, 1000);
        shot(40, 20, 38, 1000);
        for (int i = 0; i < 8; i++) begin
            pw = $urandom_range(0, 40);
            to = $urandom_range(5, 250);
            n  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 260));
            shot(pw, to, n, 1000);
        end

        // Free-running with no reads drives the FIFO into overflow.
        bus_write(ADDR_PULSE_W, 10);
        bus_write(ADDR_TIMEOUT, 100);
        bus_write(ADDR_CTRL, 32'h5);
        repeat (20 * 300) @(negedge clk);
        check("irq_when_nonempty", bus.irq, 1);
        bus_write(ADDR_CTRL, 32'h4);
        repeat (320) @(negedge clk);
        bus_read(ADDR_STATUS, 32'h0000_1006, "status_full_overflow");
        bus_read(ADDR_DATA,   32'hC000_0064, "data_overflow_record");
        bus_read(ADDR_STATUS, 32'h0000_0F04, "status_after_pop");
        bus_write(ADDR_STATUS, 32'h4);
        bus_read(ADDR_STATUS, 32'h0000_0F00, "status_overflow_w1c");
        bus_write(ADDR_CTRL, 32'hC);
        bus_read(ADDR_STATUS, 32'h0000_0001, "status_fifo_clear");
        check("irq_when_empty", bus.irq, 0);

        // Period shadowing: a mid-burst write leaves the current spacing alone.
        rise_q.delete();
        bus_write(ADDR_CTRL, 32'h1);
        wait_rises(2);
        repeat (50) @(negedge clk);
        bus_write(ADDR_PERIOD, 400);
        wait_rises(4);
        bus_write(ADDR_CTRL, 32'h0);
        r0 = rise_q[0]; r1 = rise_q[1]; r2 = rise_q[2]; r3 = rise_q[3];
        check("spacing_before_write", r1 - r0, 300);
        check("spacing_during_write", r2 - r1, 300);
        check("spacing_after_write",  r3 - r2, 400);
        repeat (420) @(negedge clk);
        check("irq_disabled", bus.irq, 0);
        bus_write(ADDR_CTRL, 32'h4);
        check("irq_enabled", bus.irq, 1);
        bus_write(ADDR_CTRL, 32'hC);
        check("irq_after_clear", bus.irq, 0);
        bus_write(ADDR_CTRL, 32'h0);

        reset_mid(10);
        reset_mid(60);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
